grid_turn_ctrl: RTL and testbench

//  Turn sequencer for the two-player grid state register (per-player wall/location X/Y flops).

---
 rtl/grid_turn_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_grid_turn_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_turn_ctrl.sv
// -----------------------------------------------------------------------------
// grid_turn_ctrl
//
// Turn sequencer for the two-player grid state register. Move requests from
// both players are arbitrated round-robin, one move per turn. The mover's
// candidate cell is computed, checked against the grid bounds and against the
// walls/locations held in the grid register. A clean move pulses that player's
// grid write enable with the next location/wall values. A colliding move ends
// the game, and the other player is the winner.
//
// Ports
//   clk                    clock, rising edge
//   clrn                   reset, asynchronous, active-high
//   start                  level; leaves IDLE when high
//   req_p1 / req_p2        move requests, held by the requester until ack
//   dir_p1 / dir_p2        00 up(y-1) 01 right(x+1) 10 down(y+1) 11 left(x-1)
//   loc_pN_x / loc_pN_y    current location of player N (from grid register)
//   wall_pN_x / wall_pN_y  current wall cell of player N (from grid register)
//   en1 / en2              one-cycle write enable to P1 / P2 grid flops
//   nxt_loc_x / nxt_loc_y  next location, shared by both players' LOC inputs
//   nxt_wall_x / nxt_wall_y next wall cell (mover's old location)
//   ack_p1 / ack_p2        one-cycle pulse: that player's request consumed
//   busy                   high in CALC, CHECK and COMMIT
//   game_over              sticky high once a move collides
//   winner                 01 P1 won, 10 P2 won, 00 none
// -----------------------------------------------------------------------------
module grid_turn_ctrl #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               start,
    input  logic               req_p1,
    input  logic [1:0]         dir_p1,
    input  logic               req_p2,
    input  logic [1:0]         dir_p2,
    input  logic [COORD_W-1:0] loc_p1_x,
    input  logic [COORD_W-1:0] loc_p1_y,
    input  logic [COORD_W-1:0] loc_p2_x,
    input  logic [COORD_W-1:0] loc_p2_y,
    input  logic [COORD_W-1:0] wall_p1_x,
    input  logic [COORD_W-1:0] wall_p1_y,
    input  logic [COORD_W-1:0] wall_p2_x,
    input  logic [COORD_W-1:0] wall_p2_y,
    output logic               en1,
    output logic               en2,
    output logic [COORD_W-1:0] nxt_loc_x,
    output logic [COORD_W-1:0] nxt_loc_y,
    output logic [COORD_W-1:0] nxt_wall_x,
    output logic [COORD_W-1:0] nxt_wall_y,
    output logic               ack_p1,
    output logic               ack_p2,
    output logic               busy,
    output logic               game_over,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_CALC   = 3'd2,
        S_CHECK  = 3'd3,
        S_COMMIT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic       PLAYER_1  = 1'b0;
    localparam logic       PLAYER_2  = 1'b1;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Candidates are one bit wider than the coordinate bus so that stepping
    // left/up from 0 lands on all-ones and is caught by the same upper-bound
    // compare as stepping off the right/bottom edge; nothing wraps.
    localparam logic [COORD_W:0] COORD_ONE = {{COORD_W{1'b0}}, 1'b1};
    localparam logic [COORD_W:0] LAST_X    = (COORD_W+1)'(GRID_W - 1);
    localparam logic [COORD_W:0] LAST_Y    = (COORD_W+1)'(GRID_H - 1);

    state_t               state_q;
    logic                 last_grant_q;
    logic                 grant_q;
    logic [1:0]           dir_q;
    logic [COORD_W-1:0]   loc_x_q;
    logic [COORD_W-1:0]   loc_y_q;
    logic [COORD_W:0]     cand_x_q;
    logic [COORD_W:0]     cand_y_q;
    logic                 oob_q;
    logic                 en1_q;
    logic                 en2_q;
    logic                 ack_p1_q;
    logic                 ack_p2_q;
    logic                 busy_q;
    logic                 game_over_q;
    logic [1:0]           winner_q;
    logic [COORD_W-1:0]   nxt_loc_x_q;
    logic [COORD_W-1:0]   nxt_loc_y_q;
    logic [COORD_W-1:0]   nxt_wall_x_q;
    logic [COORD_W-1:0]   nxt_wall_y_q;

    logic                 grant_s;
    logic [COORD_W:0]     cand_x_d;
    logic [COORD_W:0]     cand_y_d;
    logic                 oob_d;
    logic [COORD_W-1:0]   oth_loc_x_s;
    logic [COORD_W-1:0]   oth_loc_y_s;
    logic [COORD_W-1:0]   oth_wall_x_s;
    logic [COORD_W-1:0]   oth_wall_y_s;
    logic [COORD_W-1:0]   own_wall_x_s;
    logic [COORD_W-1:0]   own_wall_y_s;
    logic                 collide_s;

    // Round-robin arbitration: on a tie the player that did not move last wins.
    always_comb begin
        grant_s = PLAYER_1;
        if (req_p1 && req_p2) begin
            grant_s = ~last_grant_q;
        end else if (req_p2) begin
            grant_s = PLAYER_2;
        end else begin
            grant_s = PLAYER_1;
        end
    end

    // Candidate cell and out-of-bounds flag from the latched location/direction.
    always_comb begin
        cand_x_d = {1'b0, loc_x_q};
        cand_y_d = {1'b0, loc_y_q};
        case (dir_q)
            DIR_UP:    cand_y_d = {1'b0, loc_y_q} - COORD_ONE;
            DIR_RIGHT: cand_x_d = {1'b0, loc_x_q} + COORD_ONE;
            DIR_DOWN:  cand_y_d = {1'b0, loc_y_q} + COORD_ONE;
            DIR_LEFT:  cand_x_d = {1'b0, loc_x_q} - COORD_ONE;
            default:   cand_x_d = {1'b0, loc_x_q};
        endcase
        oob_d = (cand_x_d > LAST_X) | (cand_y_d > LAST_Y);
    end

    // Collision check against the live grid register contents.
    always_comb begin
        if (grant_q == PLAYER_2) begin
            oth_loc_x_s  = loc_p1_x;
            oth_loc_y_s  = loc_p1_y;
            oth_wall_x_s = wall_p1_x;
            oth_wall_y_s = wall_p1_y;
            own_wall_x_s = wall_p2_x;
            own_wall_y_s = wall_p2_y;
        end else begin
            oth_loc_x_s  = loc_p2_x;
            oth_loc_y_s  = loc_p2_y;
            oth_wall_x_s = wall_p2_x;
            oth_wall_y_s = wall_p2_y;
            own_wall_x_s = wall_p1_x;
            own_wall_y_s = wall_p1_y;
        end
        collide_s = oob_q
                  | ((cand_x_q == {1'b0, oth_loc_x_s})  && (cand_y_q == {1'b0, oth_loc_y_s}))
                  | ((cand_x_q == {1'b0, oth_wall_x_s}) && (cand_y_q == {1'b0, oth_wall_y_s}))
                  | ((cand_x_q == {1'b0, own_wall_x_s}) && (cand_y_q == {1'b0, own_wall_y_s}));
    end

    // Turn FSM with all outputs registered; en/ack are single-cycle pulses.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q      <= S_IDLE;
            last_grant_q <= PLAYER_2;
            grant_q      <= PLAYER_1;
            dir_q        <= 2'd0;
            loc_x_q      <= {COORD_W{1'b0}};
            loc_y_q      <= {COORD_W{1'b0}};
            cand_x_q     <= {(COORD_W+1){1'b0}};
            cand_y_q     <= {(COORD_W+1){1'b0}};
            oob_q        <= 1'b0;
            en1_q        <= 1'b0;
            en2_q        <= 1'b0;
            ack_p1_q     <= 1'b0;
            ack_p2_q     <= 1'b0;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            nxt_loc_x_q  <= {COORD_W{1'b0}};
            nxt_loc_y_q  <= {COORD_W{1'b0}};
            nxt_wall_x_q <= {COORD_W{1'b0}};
            nxt_wall_y_q <= {COORD_W{1'b0}};
        end else begin
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            ack_p1_q <= 1'b0;
            ack_p2_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (req_p1 || req_p2) begin
                        grant_q      <= grant_s;
                        last_grant_q <= grant_s;
                        dir_q        <= (grant_s == PLAYER_2) ? dir_p2 : dir_p1;
                        loc_x_q      <= (grant_s == PLAYER_2) ? loc_p2_x : loc_p1_x;
                        loc_y_q      <= (grant_s == PLAYER_2) ? loc_p2_y : loc_p1_y;
                        busy_q       <= 1'b1;
                        state_q      <= S_CALC;
                    end
                end
                S_CALC: begin
                    cand_x_q <= cand_x_d;
                    cand_y_q <= cand_y_d;
                    oob_q    <= oob_d;
                    state_q  <= S_CHECK;
                end
                S_CHECK: begin
                    ack_p1_q <= (grant_q == PLAYER_1);
                    ack_p2_q <= (grant_q == PLAYER_2);
                    if (collide_s) begin
                        busy_q      <= 1'b0;
                        game_over_q <= 1'b1;
                        winner_q    <= (grant_q == PLAYER_2) ? 2'b01 : 2'b10;
                        state_q     <= S_OVER;
                    end else begin
                        en1_q        <= (grant_q == PLAYER_1);
                        en2_q        <= (grant_q == PLAYER_2);
                        nxt_loc_x_q  <= cand_x_q[COORD_W-1:0];
                        nxt_loc_y_q  <= cand_y_q[COORD_W-1:0];
                        nxt_wall_x_q <= loc_x_q;
                        nxt_wall_y_q <= loc_y_q;
                        state_q      <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_RUN;
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign en1        = en1_q;
    assign en2        = en2_q;
    assign ack_p1     = ack_p1_q;
    assign ack_p2     = ack_p2_q;
    assign busy       = busy_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign nxt_loc_x  = nxt_loc_x_q;
    assign nxt_loc_y  = nxt_loc_y_q;
    assign nxt_wall_x = nxt_wall_x_q;
    assign nxt_wall_y = nxt_wall_y_q;

endmodule

// File: tb/tb_grid_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grid_turn_ctrl
//
// Directed scenarios followed by randomized games. The bench plays the role of
// the grid register: it keeps both players' locations and walls as plain
// integers, predicts each turn (who moves, target cell, collision, winner)
// with simple arithmetic, and drives the grid inputs from that model.
// -----------------------------------------------------------------------------
module tb_grid_turn_ctrl;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       clrn;
    logic       start;
    logic       req_p1;
    logic [1:0] dir_p1;
    logic       req_p2;
    logic [1:0] dir_p2;
    logic [7:0] loc_p1_x, loc_p1_y, loc_p2_x, loc_p2_y;
    logic [7:0] wall_p1_x, wall_p1_y, wall_p2_x, wall_p2_y;
    logic       en1, en2, ack_p1, ack_p2, busy, game_over;
    logic [7:0] nxt_loc_x, nxt_loc_y, nxt_wall_x, nxt_wall_y;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    // Model state: index 1 = P1, index 2 = P2.
    int px [1:2];
    int py [1:2];
    int wx [1:2];
    int wy [1:2];
    int last_m;
    int nlx, nly, nwx, nwy;
    int over;
    int win;

    always #5 clk = ~clk;

    grid_turn_ctrl #(.GRID_W(W), .GRID_H(H), .COORD_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .start      (start),
        .req_p1     (req_p1),
        .dir_p1     (dir_p1),
        .req_p2     (req_p2),
        .dir_p2     (dir_p2),
        .loc_p1_x   (loc_p1_x),
        .loc_p1_y   (loc_p1_y),
        .loc_p2_x   (loc_p2_x),
        .loc_p2_y   (loc_p2_y),
        .wall_p1_x  (wall_p1_x),
        .wall_p1_y  (wall_p1_y),
        .wall_p2_x  (wall_p2_x),
        .wall_p2_y  (wall_p2_y),
        .en1        (en1),
        .en2        (en2),
        .nxt_loc_x  (nxt_loc_x),
        .nxt_loc_y  (nxt_loc_y),
        .nxt_wall_x (nxt_wall_x),
        .nxt_wall_y (nxt_wall_y),
        .ack_p1     (ack_p1),
        .ack_p2     (ack_p2),
        .busy       (busy),
        .game_over  (game_over),
        .winner     (winner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_grid();
        loc_p1_x  = 8'(px[1]);
        loc_p1_y  = 8'(py[1]);
        loc_p2_x  = 8'(px[2]);
        loc_p2_y  = 8'(py[2]);
        wall_p1_x = 8'(wx[1]);
        wall_p1_y = 8'(wy[1]);
        wall_p2_x = 8'(wx[2]);
        wall_p2_y = 8'(wy[2]);
    endtask

    task automatic place(input int x1, input int y1, input int wx1, input int wy1,
                         input int x2, input int y2, input int wx2, input int wy2);
        px[1] = x1; py[1] = y1; wx[1] = wx1; wy[1] = wy1;
        px[2] = x2; py[2] = y2; wx[2] = wx2; wy[2] = wy2;
        drive_grid();
    endtask

    task automatic chk_nxt(input string tag);
        chk({tag, ".nxt_loc_x"},  32'(nxt_loc_x),  nlx);
        chk({tag, ".nxt_loc_y"},  32'(nxt_loc_y),  nly);
        chk({tag, ".nxt_wall_x"}, 32'(nxt_wall_x), nwx);
        chk({tag, ".nxt_wall_y"}, 32'(nxt_wall_y), nwy);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".en1"},    32'(en1),    32'd0);
        chk({tag, ".en2"},    32'(en2),    32'd0);
        chk({tag, ".ack_p1"}, 32'(ack_p1), 32'd0);
        chk({tag, ".ack_p2"}, 32'(ack_p2), 32'd0);
        chk({tag, ".busy"},   32'(busy),   32'd0);
        chk_nxt(tag);
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        req_p1 = 1'b0;
        req_p2 = 1'b0;
        start  = 1'b0;
        clrn   = 1'b1;
        #1;
        last_m = 2;
        nlx = 0; nly = 0; nwx = 0; nwy = 0;
        over = 0; win = 0;
        chk_quiet("reset");
        chk("reset.game_over", 32'(game_over), 32'd0);
        chk("reset.winner",    32'(winner),    32'd0);
        step();
        clrn = 1'b0;
    endtask

    task automatic begin_game();
        start = 1'b1;
        step();
        chk("run.game_over", 32'(game_over), 32'd0);
        chk("run.busy",      32'(busy),      32'd0);
    endtask

    // One turn from RUN: drive requests, predict with the model, check all phases.
    task automatic turn(input logic r1, input logic r2, input logic [1:0] d1, input logic [1:0] d2);
        int m, o, nx, ny, col;
        logic [1:0] d;
        req_p1 = r1; req_p2 = r2; dir_p1 = d1; dir_p2 = d2;
        if (!r1 && !r2) begin
            step();
            step();
            chk_quiet("noreq");
            return;
        end
        if (r1 && r2) m = (last_m == 2) ? 1 : 2;
        else          m = r1 ? 1 : 2;
        o = 3 - m;
        last_m = m;
        d  = (m == 1) ? d1 : d2;
        nx = px[m];
        ny = py[m];
        case (d)
            2'd0:    ny = ny - 1;
            2'd1:    nx = nx + 1;
            2'd2:    ny = ny + 1;
            default: nx = nx - 1;
        endcase
        col = (nx < 0 || nx >= W || ny < 0 || ny >= H) ||
              (nx == px[o] && ny == py[o]) ||
              (nx == wx[o] && ny == wy[o]) ||
              (nx == wx[m] && ny == wy[m]);
        step();
        chk("calc.busy", 32'(busy), 32'd1);
        chk("calc.en",   32'({en1, en2, ack_p1, ack_p2}), 32'd0);
        step();
        chk("check.busy", 32'(busy), 32'd1);
        chk("check.en",   32'({en1, en2, ack_p1, ack_p2}), 32'd0);
        step();
        chk("end.ack_p1", 32'(ack_p1), 32'(m == 1));
        chk("end.ack_p2", 32'(ack_p2), 32'(m == 2));
        if (col == 0) begin
            chk("commit.en1",       32'(en1),       32'(m == 1));
            chk("commit.en2",       32'(en2),       32'(m == 2));
            chk("commit.game_over", 32'(game_over), 32'd0);
            nlx = nx; nly = ny; nwx = px[m]; nwy = py[m];
            chk_nxt("commit");
            wx[m] = px[m]; wy[m] = py[m];
            px[m] = nx;    py[m] = ny;
            drive_grid();
        end else begin
            over = 1;
            win  = (o == 1) ? 1 : 2;
            chk("over.en",        32'({en1, en2}), 32'd0);
            chk("over.game_over", 32'(game_over), 32'd1);
            chk("over.winner",    32'(winner),    win);
            chk("over.busy",      32'(busy),      32'd0);
            chk_nxt("over");
        end
        if (m == 1) req_p1 = 1'b0;
        else        req_p2 = 1'b0;
        step();
        chk_quiet("after");
        chk("after.game_over", 32'(game_over), over);
    endtask

    // Once over, start and requests must have no effect.
    task automatic chk_sticky();
        for (int i = 0; i < 4; i++) begin
            start  = 1'($urandom_range(0, 1));
            req_p1 = 1'($urandom_range(0, 1));
            req_p2 = 1'($urandom_range(0, 1));
            step();
            chk_quiet("sticky");
            chk("sticky.game_over", 32'(game_over), 32'd1);
            chk("sticky.winner",    32'(winner),    win);
        end
        req_p1 = 1'b0;
        req_p2 = 1'b0;
    endtask

    initial begin
        clrn = 1'b1; start = 1'b0;
        req_p1 = 1'b0; req_p2 = 1'b0; dir_p1 = 2'd0; dir_p2 = 2'd0;
        place(0, 0, 0, 0, 0, 0, 0, 0);

        // Simple right move of P1 from (2,3).
        place(2, 3, 2, 3, 6, 6, 6, 6);
        do_reset();
        begin_game();
        turn(1'b1, 1'b0, 2'd1, 2'd0);

        // Tie after reset goes to P1, held P2 next, then alternation.
        place(2, 2, 2, 2, 5, 5, 5, 5);
        do_reset();
        begin_game();
        turn(1'b1, 1'b1, 2'd1, 2'd2);
        turn(1'b0, 1'b1, 2'd1, 2'd2);
        turn(1'b1, 1'b1, 2'd2, 2'd3);
        turn(1'b1, 1'b1, 2'd1, 2'd3);

        // P1 steps off the right edge: P2 wins.
        place(7, 5, 7, 5, 1, 1, 1, 1);
        do_reset();
        begin_game();
        turn(1'b1, 1'b0, 2'd1, 2'd0);
        chk_sticky();

        // P2 walks into P1's wall: P1 wins.
        place(4, 3, 4, 4, 4, 5, 4, 5);
        do_reset();
        begin_game();
        turn(1'b0, 1'b1, 2'd0, 2'd0);
        chk_sticky();

        // P2 at the origin steps left, then (new game) up: no wrap-around.
        place(5, 5, 5, 5, 0, 0, 0, 0);
        do_reset();
        begin_game();
        turn(1'b0, 1'b1, 2'd0, 2'd3);
        chk_sticky();
        place(5, 5, 5, 5, 0, 0, 0, 0);
        do_reset();
        begin_game();
        turn(1'b0, 1'b1, 2'd0, 2'd0);
        chk_sticky();

        // Reset while in CHECK aborts the turn and returns to IDLE.
        place(2, 3, 2, 3, 6, 6, 6, 6);
        do_reset();
        begin_game();
        req_p1 = 1'b1; dir_p1 = 2'd1;
        step();
        step();
        clrn = 1'b1;
        #1;
        last_m = 2;
        nlx = 0; nly = 0; nwx = 0; nwy = 0; over = 0;
        chk_quiet("midreset");
        chk("midreset.game_over", 32'(game_over), 32'd0);
        step();
        chk_quiet("midreset.hold");
        clrn  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet("idle");
        end
        req_p1 = 1'b0;
        begin_game();
        turn(1'b1, 1'b0, 2'd1, 2'd0);

        // Randomized games until a collision or a turn budget runs out.
        for (int g = 0; g < 12; g++) begin
            int x1, y1, x2, y2;
            x1 = $urandom_range(0, W - 1);
            y1 = $urandom_range(0, H - 1);
            do begin
                x2 = $urandom_range(0, W - 1);
                y2 = $urandom_range(0, H - 1);
            end while (x1 == x2 && y1 == y2);
            place(x1, y1, x1, y1, x2, y2, x2, y2);
            do_reset();
            begin_game();
            for (int t = 0; t < 30 && over == 0; t++) begin
                turn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            if (over != 0) chk_sticky();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
